// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the MIPS execute stage: bus layouts, funct codes
// for the HI/LO, divide and multiply instructions, and the divider state encoding.
package ex_stage_pkg;

  localparam int unsigned ID_TO_EX_WD  = 159;
  localparam int unsigned EX_TO_MEM_WD = 76;
  localparam int unsigned DIV_CYCLES   = 32;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] OpSpecial  = 6'h00;
  localparam logic [5:0] FunctMfhi  = 6'h10;
  localparam logic [5:0] FunctMthi  = 6'h11;
  localparam logic [5:0] FunctMflo  = 6'h12;
  localparam logic [5:0] FunctMtlo  = 6'h13;
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1a;
  localparam logic [5:0] FunctDivu  = 6'h1b;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  // Two's-complement negate when en is set.
  function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Pipeline-side signal bundle of the execute stage: stall vector, decode bus in,
// memory bus out, data-SRAM request, forwarding and stall request.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [5:0]              stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    ex_wreg;
  logic [4:0]              ex_waddr;
  logic [31:0]             ex_wdata;
  logic                    ex_is_load;
  logic                    stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  ex_wreg, ex_waddr, ex_wdata, ex_is_load, stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output ex_wreg, ex_waddr, ex_wdata, ex_is_load, stallreq_for_ex
  );

endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle. Signed operation divides
// magnitudes and fixes signs afterwards; divide by zero skips straight to DONE.
module ex_stage_div_iter
  import ex_stage_pkg::*;
#(
  parameter int unsigned DivCycles = DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned CntW = $clog2(DivCycles);

  div_state_e    state_q, state_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          div_by_zero;
  logic [32:0]   shifted;
  logic [33:0]   diff;

  assign div_by_zero = (divisor == 32'd0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = div_by_zero ? StDone : StBusy;
      StBusy: if (cnt_q == CntW'(DivCycles - 1)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == StBusy) || ((state_q == StIdle) && start);
    done      = (state_q == StDone);
    quotient  = neg_if(qneg_q, quo_q);
    remainder = neg_if(rneg_q, rem_q);
  end

  // The partial remainder never exceeds 2*divisor-1, so 34 bits hold the borrow.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if ((state_q == StIdle) && start) begin
      cnt_d = '0;
      dvs_d = neg_if(signed_op & divisor[31], divisor);
      if (div_by_zero) begin
        quo_d  = '1;
        rem_d  = dividend;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else begin
        quo_d  = neg_if(signed_op & dividend[31], dividend);
        rem_d  = '0;
        qneg_d = signed_op & (dividend[31] ^ divisor[31]);
        rneg_d = signed_op & dividend[31];
      end
    end else if (state_q == StBusy) begin
      rem_d = diff[33] ? shifted[31:0] : diff[31:0];
      quo_d = {quo_q[30:0], ~diff[33]};
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: input register, one-hot ALU, HI/LO registers and iterative divider.
// Define EX_MULT_EN to execute mult/multu in one cycle; otherwise they act as nops.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  id_ex_t      id_in, id_q, id_d;
  logic        load, bubble;
  logic [5:0]  funct;
  logic        special;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, is_divu, is_mult, is_multu;
  logic [31:0] src1, src2, imm_sext, imm_zext;
  logic [4:0]  shamt;
  logic [31:0] alu_res, ex_result;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        div_done_q, div_done_d;
  logic        div_start, div_busy, div_fin;
  logic [31:0] div_quo, div_rem;
  ex_mem_t     ex_mem;

  assign id_in  = id_ex_t'(bus.id_to_ex_bus);
  assign load   = (bus.stall[2] == NoStop);
  assign bubble = (bus.stall[2] == Stop) && (bus.stall[3] == NoStop);

  always_comb begin
    id_d = id_q;
    if (bubble) begin
      id_d = '0;
    end else if (load) begin
      id_d = id_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end

  assign special  = (id_q.inst[31:26] == OpSpecial);
  assign funct    = id_q.inst[5:0];
  assign is_mfhi  = special && (funct == FunctMfhi);
  assign is_mflo  = special && (funct == FunctMflo);
  assign is_mthi  = special && (funct == FunctMthi);
  assign is_mtlo  = special && (funct == FunctMtlo);
  assign is_div   = special && (funct == FunctDiv);
  assign is_divu  = special && (funct == FunctDivu);
  assign is_mult  = special && (funct == FunctMult);
  assign is_multu = special && (funct == FunctMultu);

  assign imm_sext = {{16{id_q.inst[15]}}, id_q.inst[15:0]};
  assign imm_zext = {16'h0000, id_q.inst[15:0]};

  // Operand selects are one-hot; an all-zero select yields zero.
  assign src1 = ({32{id_q.sel_alu_src1[0]}} & id_q.rdata1)
              | ({32{id_q.sel_alu_src1[1]}} & id_q.pc)
              | ({32{id_q.sel_alu_src1[2]}} & {27'd0, id_q.inst[10:6]});
  assign src2 = ({32{id_q.sel_alu_src2[0]}} & id_q.rdata2)
              | ({32{id_q.sel_alu_src2[1]}} & imm_sext)
              | ({32{id_q.sel_alu_src2[2]}} & 32'd8)
              | ({32{id_q.sel_alu_src2[3]}} & imm_zext);
  assign shamt = src1[4:0];

  always_comb begin
    alu_res = ({32{id_q.alu_op[11]}} & (src1 + src2))
            | ({32{id_q.alu_op[10]}} & (src1 - src2))
            | ({32{id_q.alu_op[9]}}  & {31'd0, $signed(src1) < $signed(src2)})
            | ({32{id_q.alu_op[8]}}  & {31'd0, src1 < src2})
            | ({32{id_q.alu_op[7]}}  & (src1 & src2))
            | ({32{id_q.alu_op[6]}}  & ~(src1 | src2))
            | ({32{id_q.alu_op[5]}}  & (src1 | src2))
            | ({32{id_q.alu_op[4]}}  & (src1 ^ src2))
            | ({32{id_q.alu_op[3]}}  & (src2 << shamt))
            | ({32{id_q.alu_op[2]}}  & (src2 >> shamt))
            | ({32{id_q.alu_op[1]}}  & 32'($signed(src2) >>> shamt))
            | ({32{id_q.alu_op[0]}}  & {src2[15:0], 16'h0000});
  end

  always_comb begin
    if (is_mfhi) begin
      ex_result = hi_q;
    end else if (is_mflo) begin
      ex_result = lo_q;
    end else begin
      ex_result = alu_res;
    end
  end

  // A div held in EX after completing must not restart until a new instruction loads.
  assign div_start = (is_div || is_divu) && !div_done_q;

  ex_stage_div_iter #(
    .DivCycles (DIV_CYCLES)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (is_div),
    .dividend  (id_q.rdata1),
    .divisor   (id_q.rdata2),
    .busy      (div_busy),
    .done      (div_fin),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    div_done_d = div_done_q;
    if (load || bubble) begin
      div_done_d = 1'b0;
    end else if (div_fin) begin
      div_done_d = 1'b1;
    end
  end

`ifdef EX_MULT_EN
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = is_mult ? {{32{id_q.rdata1[31]}}, id_q.rdata1} : {32'd0, id_q.rdata1};
  assign mul_b   = is_mult ? {{32{id_q.rdata2[31]}}, id_q.rdata2} : {32'd0, id_q.rdata2};
  assign product = mul_a * mul_b;
`else
  logic unused_mult;
  assign unused_mult = is_mult | is_multu;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_fin) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end else if (load) begin
      if (is_mthi) hi_d = id_q.rdata1;
      if (is_mtlo) lo_d = id_q.rdata1;
`ifdef EX_MULT_EN
      if (is_mult || is_multu) {hi_d, lo_d} = product;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      div_done_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_done_q <= div_done_d;
    end
  end

  always_comb begin
    ex_mem.pc           = id_q.pc;
    ex_mem.data_ram_en  = id_q.data_ram_en;
    ex_mem.data_ram_wen = id_q.data_ram_wen;
    ex_mem.sel_rf_res   = id_q.sel_rf_res;
    ex_mem.rf_we        = id_q.rf_we;
    ex_mem.rf_waddr     = id_q.rf_waddr;
    ex_mem.ex_result    = ex_result;
  end

  assign bus.ex_to_mem_bus   = ex_mem;
  assign bus.data_sram_en    = id_q.data_ram_en;
  assign bus.data_sram_wen   = id_q.data_ram_wen;
  assign bus.data_sram_addr  = alu_res;
  assign bus.data_sram_wdata = id_q.rdata2;
  assign bus.ex_wreg         = id_q.rf_we;
  assign bus.ex_waddr        = id_q.rf_waddr;
  assign bus.ex_wdata        = ex_result;
  assign bus.ex_is_load      = id_q.data_ram_en & id_q.sel_rf_res;
  assign bus.stallreq_for_ex = div_busy;

  logic unused_bits;
  assign unused_bits = ^{bus.stall[5:4], bus.stall[1:0], id_q.inst[25:16]};

endmodule
